sram_controller: RTL
====================

# sram_controller

Memory-stage responder that turns one 32-bit load or store from the pipeline into two sequential 16-bit accesses on an external asynchronous SRAM. It holds the pipeline with `ready` until both halves finish. It sits between the MEM stage and the board SRAM pins, and replaces the on-chip data memory in the SRAM build.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles each half-access is held on the pins. Range 0..7.
- `BASE_ADDR`, default 1024: CPU byte address that maps to SRAM word 0.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: store request from MEM stage.
- `rd_en` input 1: load request from MEM stage.
- `address` input 32: CPU byte address, word-aligned.
- `write_data` input 32: store data.
- `read_data` output 32: load result. Holds its value until the next load completes.
- `ready` output 1: high means no transaction is pending. Low freezes the pipeline.
- `SRAM_DQ` inout 16: SRAM data bus. Driven only while a write half is active, otherwise high-Z.
- `SRAM_ADDR` output 18: SRAM halfword address.
- `SRAM_WE_N` output 1: active-low write enable.
- `SRAM_OE_N` output 1: active-low output enable. `SRAM_CE_N`, `SRAM_LB_N` and `SRAM_UB_N` are tied 0.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `rd_en|wr_en` = 1 moves the block to LOW.
  - On that edge it latches `address`, `write_data` and the operation (op = write if `wr_en`, else read).
  - `wr_en` and `rd_en` both high is treated as a write.
- LOW:
  - `SRAM_ADDR` = {(latched address − `BASE_ADDR`)[18:2], 1'b0}.
  - Stays for `WAIT_CYCLES`+1 cycles, counted by the wait counter, then moves to HIGH.
- HIGH:
  - Same address with bit 0 = 1.
  - Stays for `WAIT_CYCLES`+1 cycles, then moves to DONE.
- DONE: lasts one cycle, then the block returns to IDLE unconditionally.
- Write halves:
  - `SRAM_WE_N` = 0 and `SRAM_OE_N` = 1.
  - `SRAM_DQ` = `write_data`[15:0] in LOW and `write_data`[31:16] in HIGH.
- Read halves:
  - `SRAM_OE_N` = 0 and `SRAM_WE_N` = 1.
  - In the last cycle of LOW, `SRAM_DQ` is captured into `read_data`[15:0].
  - In the last cycle of HIGH, it is captured into `read_data`[31:16].
  - Both capture registers update together at the DONE entry edge. `read_data` therefore never shows a mixed old/new word.
- IDLE and DONE: `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_DQ` high-Z, `SRAM_ADDR` holds its last value.
- `ready` = (state == IDLE && !(rd_en|wr_en)) || state == DONE. This is combinational, so the stall asserts in the same cycle the request appears.
- Address arithmetic is 32-bit unsigned. Addresses below `BASE_ADDR` wrap. Address bits above bit 18 after the subtraction are ignored.

## Timing
- Reset values:
  - state = IDLE and wait counter = 0.
  - `read_data` = 0.
  - `SRAM_WE_N` = 1 and `SRAM_OE_N` = 1.
  - `SRAM_ADDR` = 0 and `SRAM_DQ` high-Z.
  - `ready` = 1 while no request is present.
- Transaction timeline, with the request first seen in cycle 0:
  - Cycle 0 is in IDLE with `ready` = 0.
  - LOW covers cycles 1..W+1.
  - HIGH covers cycles W+2..2W+2.
  - DONE is cycle 2W+3 with `ready` = 1.
  - With W = 1, `ready` is high in cycle 5, so the stall is 5 cycles.
- Back-to-back requests: the pipeline advances at the edge ending DONE. A request present in the following IDLE cycle starts a new transaction with no dead cycle beyond that IDLE cycle.
- All SRAM outputs are decoded only from registered state, the counter and latched data. There are no combinational paths from MEM-stage inputs to the pins.
- Request inputs that change mid-transaction are ignored; only the latched copy is used.
- Reset mid-transaction:
  - On the next edge the block returns to IDLE.
  - `SRAM_WE_N` goes to 1 and `SRAM_DQ` releases.
  - A partially written word is allowed.
  - `read_data` resets to 0.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - `SRAM_ADDR_W` = 18 and `SRAM_DATA_W` = 16;
  - the default `BASE_ADDR`.
- One natural sub-module, `sram_wait_counter`:
  - a 3-bit counter with clear and enable;
  - it outputs `last` when count == `WAIT_CYCLES`.

## Test plan
- Store, W = 1: `wr_en`, address 1024, data 0xDEADBEEF.
  - Expect halfword 0 = 0xBEEF and halfword 1 = 0xDEAD.
  - Expect `SRAM_WE_N` low for 2 cycles per half and `ready` high in cycle 5.
- Load after store: `rd_en`, address 1024.
  - Expect `read_data` = 0xDEADBEEF in the DONE cycle.
  - Expect `SRAM_OE_N` low for cycles 1..4 and `SRAM_WE_N` high throughout.
- Address mapping: store 0x12345678 to address 1032.
  - Expect `SRAM_ADDR` = 4 in LOW and 5 in HIGH.
- Back-to-back: load 1024 immediately after DONE.
  - Expect a new LOW at cycle 1 relative to the new request and correct data.
  - Expect `read_data` to hold the previous value until the new DONE.
- Both enables plus W = 0: `wr_en` = `rd_en` = 1 with data 0x0000FFFF.
  - Expect a write to be performed.
  - Expect `ready` high in cycle 3.
- Reset in HIGH of a store:
  - Expect state IDLE, `SRAM_WE_N` = 1, `SRAM_DQ` = Z and `read_data` = 0 on the next edge.
  - Expect `ready` = 1 with no request present.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the split 32-to-16-bit SRAM memory-stage controller.
package sram_ctrl_pkg;
   localparam int unsigned SRAM_ADDR_W = 18;
   localparam int unsigned SRAM_DATA_W = 16;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait counter: counts cycles spent in one half-access, flags the final cycle.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);
   logic [2:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 3'd1;
      end
   end

   assign last = (count == 3'(WAIT_CYCLES));
endmodule

// File: rtl/sram_controller.sv
// MEM-stage responder splitting each 32-bit load/store into two 16-bit async SRAM accesses,
// stalling the pipeline via ready until both halves complete.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_UB_N
);
   state_t                 state, state_nxt;
   logic                   req;
   logic                   busy;
   logic                   last;
   logic                   op_wr;
   logic [31:0]            wdata_q;
   logic [SRAM_DATA_W-1:0] rd_lo;
   logic [16:0]            word_off;

   assign req  = rd_en | wr_en;
   assign busy = (state == LOW) || (state == HIGH);

   // Word offset from the SRAM window; wraps below BASE_ADDR, bits above 18 dropped.
   assign word_off = 17'((address - BASE_ADDR) >> 2);

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk (clk),
      .rst (rst),
      .clr (!busy || last),
      .en  (busy),
      .last(last)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req)  state_nxt = LOW;
         LOW:     if (last) state_nxt = HIGH;
         HIGH:    if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_wr     <= 1'b0;
         wdata_q   <= '0;
         rd_lo     <= '0;
         read_data <= '0;
         SRAM_ADDR <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req) begin
                  op_wr     <= wr_en;
                  wdata_q   <= write_data;
                  SRAM_ADDR <= {word_off, 1'b0};
               end
            end
            LOW: begin
               if (last) begin
                  SRAM_ADDR[0] <= 1'b1;
                  if (!op_wr) rd_lo <= SRAM_DQ;
               end
            end
            // Low half is staged so read_data flips to the whole new word in one edge.
            HIGH: begin
               if (last && !op_wr) read_data <= {SRAM_DQ, rd_lo};
            end
            default: ;
         endcase
      end
   end

   assign SRAM_WE_N = !(busy && op_wr);
   assign SRAM_OE_N = !(busy && !op_wr);
   assign SRAM_DQ   = (busy && op_wr) ? ((state == LOW) ? wdata_q[15:0] : wdata_q[31:16]) : 'z;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_UB_N = 1'b0;

   assign ready = ((state == IDLE) && !req) || (state == DONE);
endmodule
